sobel_filter: RTL

//  Streaming 3x3 Sobel gradient stage of edge_detection_top.

---
 rtl/edge_detection_pkg.sv | 31 +++
 rtl/sobel_window.sv | 42 ++++
 rtl/sobel_filter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/edge_detection_pkg.sv
// Shared types and Sobel constants for the edge-detection pipeline.
package edge_detection_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    // 3x3 Sobel kernel: outer taps weigh 1, the middle tap of each column/row weighs 2
    localparam int SOBEL_SIDE = 1;
    localparam int SOBEL_MID  = 2;
    localparam int MAG_MAX    = 255;

    typedef logic signed [10:0] grad_t;

    function automatic grad_t tri_sum(input pixel_t a, input pixel_t b, input pixel_t c);
        return grad_t'(SOBEL_SIDE) * grad_t'(a)
             + grad_t'(SOBEL_MID)  * grad_t'(b)
             + grad_t'(SOBEL_SIDE) * grad_t'(c);
    endfunction

    function automatic logic [10:0] abs_grad(input grad_t g);
        grad_t a;
        a = g[10] ? -g : g;
        return a;
    endfunction

endpackage

// File: rtl/sobel_window.sv
// Two-row-plus-three pixel line buffer exposing the 3x3 Sobel window.
module sobel_window #(
    parameter int WIDTH = 720
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  shift_en,
    input  logic [7:0]            din,
    output logic [2:0][2:0][7:0]  win
);

    // Tap 0 is the pixel entering this cycle; the registers hold taps 1..2W+2.
    // The window therefore shows the post-shift view whenever shift_en is high.
    localparam int LEN = 2*WIDTH + 2;

    logic [LEN-1:0][7:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (shift_en)
            sr_d = {sr_q[LEN-2:0], din};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            sr_q <= '0;
        else
            sr_q <= sr_d;
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            localparam int T = (2-r)*WIDTH + (2-c);
            if (T == 0) begin : g_new
                assign win[r][c] = din;
            end else begin : g_reg
                assign win[r][c] = sr_q[T-1];
            end
        end
    end

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel magnitude stage: one clamped edge byte per input pixel, raster order.
module sobel_filter
    import edge_detection_pkg::*;
#(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_empty,
    input  logic [7:0] in_dout,
    output logic       in_rd_en,
    input  logic       out_full,
    output logic [7:0] out_din,
    output logic       out_wr_en
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(NPIX);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [7:0]         obuf_q, obuf_d;
    logic               obuf_valid_q, obuf_valid_d;
    logic               run_en_q;

    logic               src_ok, advance, load, last_pix, last_flush, wr;
    logic [7:0]         pix_in;
    logic [2:0][2:0][7:0] win;
    grad_t              gx, gy;
    logic [11:0]        sum, mag;
    logic               border;
    logic [7:0]         result;

    // Holds the source idle until the first clock after reset release,
    // so nothing is popped while reset is asserted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            run_en_q <= 1'b0;
        else
            run_en_q <= 1'b1;
    end

    always_comb begin
        src_ok     = (state_q == S_FLUSH) ? 1'b1 : ~in_empty;
        wr         = obuf_valid_q & ~out_full;
        advance    = run_en_q & src_ok & (~obuf_valid_q | ~out_full);
        load       = advance & (state_q != S_FILL);
        pix_in     = (state_q == S_FLUSH) ? 8'h00 : in_dout;
        last_pix   = (state_q == S_RUN)   && (cnt_q == CNT_W'(NPIX-1));
        last_flush = (state_q == S_FLUSH) && (cnt_q == CNT_W'(WIDTH));
    end

    sobel_window #(.WIDTH(WIDTH)) u_window (
        .clock    (clock),
        .reset    (reset),
        .shift_en (advance),
        .din      (pix_in),
        .win      (win)
    );

    // FSM: state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= S_FILL;
        else
            state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (advance) begin
            case (state_q)
                S_FILL:  if (cnt_q == CNT_W'(WIDTH)) state_d = S_RUN;
                S_RUN:   if (last_pix)               state_d = S_FLUSH;
                S_FLUSH: if (last_flush)             state_d = S_FILL;
                default:                             state_d = S_FILL;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        in_rd_en  = advance & (state_q != S_FLUSH);
        out_wr_en = wr;
        out_din   = obuf_q;
    end

    // cnt is the pop index through FILL/RUN, then the dummy index in FLUSH
    always_comb begin
        cnt_d = cnt_q;
        col_d = col_q;
        row_d = row_q;
        if (advance)
            cnt_d = (last_pix || last_flush) ? '0 : cnt_q + 1'b1;
        if (load) begin
            if (col_q == COL_W'(WIDTH-1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(HEIGHT-1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_comb begin
        gx     = tri_sum(win[0][2], win[1][2], win[2][2]) - tri_sum(win[0][0], win[1][0], win[2][0]);
        gy     = tri_sum(win[2][0], win[2][1], win[2][2]) - tri_sum(win[0][0], win[0][1], win[0][2]);
        sum    = {1'b0, abs_grad(gx)} + {1'b0, abs_grad(gy)};
        mag    = sum >> 1;
        border = (row_q == '0) || (row_q == ROW_W'(HEIGHT-1)) ||
                 (col_q == '0) || (col_q == COL_W'(WIDTH-1));
        if (border)
            result = 8'h00;
        else if (mag > 12'(MAG_MAX))
            result = 8'(MAG_MAX);
        else
            result = mag[7:0];
    end

    always_comb begin
        obuf_d       = load ? result : obuf_q;
        obuf_valid_d = load | (obuf_valid_q & ~wr);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            obuf_q       <= '0;
            obuf_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            obuf_q       <= obuf_d;
            obuf_valid_q <= obuf_valid_d;
        end
    end

endmodule
